// File: rtl/ccff_loader_pkg.sv
// Shared definitions for the configuration-chain loader.
//   state_t  : loader state machine encoding
//   ceil_div : integer ceiling division, e.g. words needed to cover a chain
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/ccff_piso.sv
// Word-wide shift register with a bit counter.
//   SIPO = 0 : parallel-in serial-out. load captures load_data and load_bits;
//              each shift moves the word one place toward bit 0 and counts
//              down. next_bit is the bit that will sit at bit 0 after the
//              next shift; last is high while the final bit is at bit 0.
//   SIPO = 1 : serial-in parallel-out. load clears the word; each shift
//              writes serial_in at the next position, LSB first, so a
//              partial word stays right-justified with zero upper bits.
// Ports: clk, srst (sync active-high), load, load_data, load_bits, shift,
//        serial_in, par_out, next_bit, last.
module ccff_piso
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int BIT_W  = $clog2(WORD_W + 1),
  parameter bit SIPO   = 1'b0
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic [BIT_W-1:0]  load_bits,
  input  logic              shift,
  input  logic              serial_in,
  output logic [WORD_W-1:0] par_out,
  output logic              next_bit,
  output logic              last
);

  logic [WORD_W-1:0] shreg_reg;
  logic [BIT_W-1:0]  cnt_reg;

  // Each mode leaves some inputs idle; fold them here so they read as used.
  logic unused_inputs;
  assign unused_inputs = ^{serial_in, load_data, load_bits};

  assign par_out = shreg_reg;

  generate
    if (SIPO) begin : g_sipo
      always_ff @(posedge clk) begin
        if (srst) begin
          shreg_reg <= '0;
          cnt_reg   <= '0;
        end else if (load) begin
          shreg_reg <= '0;
          cnt_reg   <= '0;
        end else if (shift) begin
          for (int i = 0; i < WORD_W; i++) begin
            if (cnt_reg == BIT_W'(i)) shreg_reg[i] <= serial_in;
          end
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
      assign next_bit = 1'b0;
      assign last     = 1'b0;
    end else begin : g_piso
      always_ff @(posedge clk) begin
        if (srst) begin
          shreg_reg <= '0;
          cnt_reg   <= '0;
        end else if (load) begin
          shreg_reg <= load_data;
          cnt_reg   <= load_bits;
        end else if (shift) begin
          shreg_reg <= shreg_reg >> 1;
          cnt_reg   <= cnt_reg - 1'b1;
        end
      end
      if (WORD_W > 1) begin : g_next
        assign next_bit = shreg_reg[1];
      end else begin : g_next1
        assign next_bit = 1'b0;
      end
      assign last = (cnt_reg == BIT_W'(1));
    end
  endgenerate

endmodule

// File: rtl/ccff_chain_loader.sv
// Source end of the fabric configuration chain. Accepts bitstream words over
// valid/ready and shifts them LSB first into ccff_head, one bit per prog_clk
// with ccff_shift_en high, for exactly CHAIN_LEN shifts per load. The last
// word contributes only the bits still needed; its upper bits are dropped.
// Ports: prog_clk, prog_reset (sync active-high), start, cfg_data, cfg_valid,
//        cfg_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done.
// Build option CCFF_READBACK_EN adds rb_data/rb_valid: the bits leaving the
// chain on ccff_tail during a load are regrouped into words, LSB first, and
// rb_valid pulses the cycle after each word (or final partial word) fills.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int  CHAIN_LEN = 22,
  parameter int  WORD_W    = 8,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done
`ifdef CCFF_READBACK_EN
  ,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
`endif
);

  localparam int BIT_W = $clog2(WORD_W + 1);

  state_t           state_reg;
  logic [CNT_W-1:0] bits_left_reg;
  logic [BIT_W-1:0] word_bits;
  logic             load_word;
  logic             shift_word;
  logic             piso_next;
  logic             piso_last;
  logic [WORD_W-1:0] unused_piso_par;

  // Bits this word contributes: a full word, or whatever remains of the chain.
  always_comb begin
    word_bits = BIT_W'(WORD_W);
    if (int'(bits_left_reg) < WORD_W) word_bits = BIT_W'(bits_left_reg);
  end

  // cfg_ready is high throughout LOAD, so valid alone completes the handshake.
  assign load_word  = (state_reg == LOAD) && cfg_valid;
  assign shift_word = (state_reg == SHIFT);

  ccff_piso #(
    .WORD_W (WORD_W),
    .BIT_W  (BIT_W),
    .SIPO   (1'b0)
  ) u_piso (
    .clk       (prog_clk),
    .srst      (prog_reset),
    .load      (load_word),
    .load_data (cfg_data),
    .load_bits (word_bits),
    .shift     (shift_word),
    .serial_in (1'b0),
    .par_out   (unused_piso_par),
    .next_bit  (piso_next),
    .last      (piso_last)
  );

  // ccff_head is registered one step ahead of the shift register so it is
  // stable for the whole shift_en-high cycle and low otherwise.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_reg     <= IDLE;
      bits_left_reg <= '0;
      cfg_ready     <= 1'b0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg     <= LOAD;
            bits_left_reg <= CNT_W'(CHAIN_LEN);
            cfg_ready     <= 1'b1;
            busy          <= 1'b1;
            done          <= 1'b0;
          end
        end
        LOAD: begin
          if (cfg_valid) begin
            state_reg     <= SHIFT;
            cfg_ready     <= 1'b0;
            ccff_shift_en <= 1'b1;
            ccff_head     <= cfg_data[0];
          end
        end
        SHIFT: begin
          bits_left_reg <= bits_left_reg - 1'b1;
          if (bits_left_reg == CNT_W'(1)) begin
            state_reg     <= DONE;
            ccff_shift_en <= 1'b0;
            ccff_head     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b1;
          end else if (piso_last) begin
            state_reg     <= LOAD;
            cfg_ready     <= 1'b1;
            ccff_shift_en <= 1'b0;
            ccff_head     <= 1'b0;
          end else begin
            ccff_head <= piso_next;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef CCFF_READBACK_EN
  logic unused_rb_next;
  logic unused_rb_last;

  // ccff_tail carries the old chain content; it is sampled at the same edge
  // that shifts the chain, i.e. before the shift replaces it.
  ccff_piso #(
    .WORD_W (WORD_W),
    .BIT_W  (BIT_W),
    .SIPO   (1'b1)
  ) u_rb (
    .clk       (prog_clk),
    .srst      (prog_reset),
    .load      (load_word),
    .load_data ('0),
    .load_bits ('0),
    .shift     (shift_word),
    .serial_in (ccff_tail),
    .par_out   (rb_data),
    .next_bit  (unused_rb_next),
    .last      (unused_rb_last)
  );

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= shift_word && ((bits_left_reg == CNT_W'(1)) || piso_last);
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule
